// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router blocks (FIFO, FSM, synchronizer).
package router_pkg;

   localparam int unsigned DEF_NUM_CH  = 3;
   localparam int unsigned DEF_ADDR_W  = 2;
   localparam int unsigned DEF_TIMEOUT = 30;

   // Ceiling log2, at least 1 so a counter is never zero bits wide.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned bits;
      bits = 1;
      while ((32'd1 << bits) < value) begin
         bits = bits + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall timer: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_sync_timer
   import router_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic vld,
   input  logic rd,
   output logic soft_reset
);

   localparam int unsigned CNT_W = clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             soft_reset_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q        <= '0;
         soft_reset_q <= 1'b0;
      end else if (!vld || rd) begin
         cnt_q        <= '0;
         soft_reset_q <= 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q        <= '0;
         soft_reset_q <= 1'b1;
      end else begin
         cnt_q        <= cnt_q + CNT_W'(1);
         soft_reset_q <= 1'b0;
      end
   end

   assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_n.sv
// Write-side synchronizer for the N-output router: latches the destination,
// steers write enables, muxes the full flag and watches each channel for stalls.
module router_sync_n
   import router_pkg::*;
#(
   parameter int unsigned NUM_CH  = DEF_NUM_CH,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              detect_add,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              write_enb_reg,
   input  logic [NUM_CH-1:0] empty,
   input  logic [NUM_CH-1:0] full,
   input  logic [NUM_CH-1:0] read_enb,
   output logic [NUM_CH-1:0] write_enb,
   output logic              fifo_full,
   output logic [NUM_CH-1:0] vld_out,
   output logic [NUM_CH-1:0] soft_reset,
   output logic              addr_err
);

   logic [ADDR_W-1:0] addr_q;
   logic              addr_ok_q;
   logic              addr_err_q;
   logic              in_range;

   assign in_range = (32'(data_in) < NUM_CH);

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q     <= '0;
         addr_ok_q  <= 1'b0;
         addr_err_q <= 1'b0;
      end else if (detect_add) begin
         addr_q     <= data_in;
         addr_ok_q  <= in_range;
         addr_err_q <= !in_range;
      end
   end

   // Out-of-range addresses select nothing, so the packet is drained and dropped.
   always_comb begin
      write_enb = '0;
      fifo_full = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (addr_ok_q && (32'(addr_q) == i)) begin
            write_enb[i] = write_enb_reg;
            fifo_full    = full[i];
         end
      end
   end

   assign vld_out  = ~empty;
   assign addr_err = addr_err_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
      router_sync_timer #(
         .TIMEOUT(TIMEOUT)
      ) u_timer (
         .clock      (clock),
         .reset      (reset),
         .vld        (vld_out[g]),
         .rd         (read_enb[g]),
         .soft_reset (soft_reset[g])
      );
   end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n with the default 3-channel, 30-cycle configuration.
module tb_router_sync_n;

   logic       clock;
   logic       reset;
   logic       detect_add;
   logic [1:0] data_in;
   logic       write_enb_reg;
   logic [2:0] empty;
   logic [2:0] full;
   logic [2:0] read_enb;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic [2:0] vld_out;
   logic [2:0] soft_reset;
   logic       addr_err;

   int n_vec;
   int n_err;

   router_sync_n #(
      .NUM_CH  (3),
      .ADDR_W  (2),
      .TIMEOUT (30)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .detect_add    (detect_add),
      .data_in       (data_in),
      .write_enb_reg (write_enb_reg),
      .empty         (empty),
      .full          (full),
      .read_enb      (read_enb),
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .vld_out       (vld_out),
      .soft_reset    (soft_reset),
      .addr_err      (addr_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      reset         = 1'b1;
      detect_add    = 1'b0;
      data_in       = 2'd0;
      write_enb_reg = 1'b0;
      empty         = 3'b101;
      full          = 3'b000;
      read_enb      = 3'b000;

      // Reset state
      tick(2);
      check("rst_write_enb", 32'(write_enb), 32'h0);
      check("rst_fifo_full", 32'(fifo_full), 32'h0);
      check("rst_soft_reset", 32'(soft_reset), 32'h0);
      check("rst_addr_err", 32'(addr_err), 32'h0);
      check("rst_vld_out", 32'(vld_out), 32'h2);
      reset = 1'b0;
      empty = 3'b111;
      tick(1);

      // Valid address 2
      detect_add = 1'b1;
      data_in    = 2'd2;
      tick(1);
      detect_add    = 1'b0;
      write_enb_reg = 1'b1;
      full          = 3'b100;
      #1;
      check("va_write_enb", 32'(write_enb), 32'h4);
      check("va_fifo_full", 32'(fifo_full), 32'h1);
      check("va_addr_err", 32'(addr_err), 32'h0);
      full = 3'b000;
      #1;
      check("va_full_drop", 32'(fifo_full), 32'h0);

      // detect_add with write_enb_reg: old address still steers this cycle
      detect_add = 1'b1;
      data_in    = 2'd3;
      #1;
      check("same_cyc_write_enb", 32'(write_enb), 32'h4);
      tick(1);
      detect_add = 1'b0;
      full       = 3'b111;
      #1;
      check("ia_addr_err", 32'(addr_err), 32'h1);
      check("ia_write_enb", 32'(write_enb), 32'h0);
      check("ia_fifo_full", 32'(fifo_full), 32'h0);

      // Back to address 0
      detect_add = 1'b1;
      data_in    = 2'd0;
      full       = 3'b000;
      tick(1);
      detect_add = 1'b0;
      full       = 3'b001;
      #1;
      check("a0_addr_err", 32'(addr_err), 32'h0);
      check("a0_write_enb", 32'(write_enb), 32'h1);
      check("a0_fifo_full", 32'(fifo_full), 32'h1);
      write_enb_reg = 1'b0;
      full          = 3'b000;
      #1;
      check("a0_idle_write_enb", 32'(write_enb), 32'h0);

      // Timeout on channel 1: pulses after edges 30 and 60
      empty = 3'b101;
      #1;
      check("to_vld_out", 32'(vld_out), 32'h2);
      for (int e = 1; e <= 61; e++) begin
         tick(1);
         check($sformatf("to_e%0d", e), 32'(soft_reset), (e == 30 || e == 60) ? 32'h2 : 32'h0);
      end
      empty = 3'b111;
      tick(1);

      // Read rescue at count 29
      empty = 3'b101;
      for (int e = 1; e <= 61; e++) begin
         read_enb = (e == 30) ? 3'b010 : 3'b000;
         tick(1);
         check($sformatf("rr_e%0d", e), 32'(soft_reset), (e == 60) ? 32'h2 : 32'h0);
      end
      read_enb = 3'b000;
      empty    = 3'b111;
      tick(1);

      // Reset pulse at count 20, first pulse 30 edges after release
      empty = 3'b101;
      for (int e = 1; e <= 52; e++) begin
         reset = (e == 21);
         tick(1);
         check($sformatf("rm_e%0d", e), 32'(soft_reset), (e == 51) ? 32'h2 : 32'h0);
      end
      reset = 1'b0;
      empty = 3'b111;
      tick(1);

      // Simultaneous stall on channels 0 and 2
      empty = 3'b010;
      for (int e = 1; e <= 31; e++) begin
         tick(1);
         check($sformatf("sim_e%0d", e), 32'(soft_reset), (e == 30) ? 32'h5 : 32'h0);
      end
      empty = 3'b111;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised write-side synchronizer for the N-output router. It latches the destination address on `detect_add` and steers `write_enb_reg` to one of `NUM_CH` FIFOs. It returns the selected FIFO's full flag to the router FSM, drives per-channel `vld_out` from the FIFO empty flags, and raises a one-cycle per-channel `soft_reset` when a channel holds valid data unread for `TIMEOUT` cycles. Compared with the 1x3 version, it adds a configurable channel count and timeout, plus out-of-range address detection (`addr_err`).

## Interface
- `NUM_CH`, 3, number of output channels/FIFOs (≥2)
- `ADDR_W`, 2, address field width; must satisfy 2**ADDR_W ≥ NUM_CH
- `TIMEOUT`, 30, qualifying idle cycles before `soft_reset` (≥2)

- `clock` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `detect_add` in 1: latch `data_in` as destination this edge
- `data_in` in ADDR_W: destination address
- `write_enb_reg` in 1: FSM write request
- `empty` in NUM_CH: FIFO empty flags
- `full` in NUM_CH: FIFO full flags
- `read_enb` in NUM_CH: FIFO read strobes from the consumers
- `write_enb` out NUM_CH: one-hot FIFO write enable
- `fifo_full` out 1: full flag of the selected FIFO
- `vld_out` out NUM_CH: per-channel data-available flag
- `soft_reset` out NUM_CH: per-channel timeout pulse
- `addr_err` out 1: last latched address ≥ NUM_CH

## Operation
- **Address register**
  - On an edge with `detect_add`=1: `addr_q`←`data_in`, `addr_ok`←(`data_in` < NUM_CH), `addr_err`←!(`data_in` < NUM_CH).
  - Otherwise these three registers hold.
- **write_enb** (combinational): one-hot(`addr_q`) when `write_enb_reg` && `addr_ok`; else 0. It never has more than one bit set.
- **fifo_full** (combinational): `full[addr_q]` when `addr_ok`; else 0. An invalid-address packet is therefore drained by the FSM and dropped (no FIFO written).
- **vld_out** (combinational): `vld_out[i]` = !`empty[i]`. It is independent of reset.
- **Per-channel timer i**, counter width clog2(TIMEOUT), evaluated in priority order:
  - `reset`: cnt←0, `soft_reset[i]`←0.
  - !`vld_out[i]` or `read_enb[i]`: cnt←0, `soft_reset[i]`←0.
  - cnt == TIMEOUT-1: cnt←0, `soft_reset[i]`←1.
  - Otherwise: cnt←cnt+1, `soft_reset[i]`←0.
- `soft_reset` is registered and lasts exactly one cycle. If the stall persists, it repeats every TIMEOUT cycles.
- Channels are fully independent. Several `soft_reset` bits may assert in the same cycle.
- `soft_reset` does not alter `addr_q`/`addr_ok`. The router FSM handles recovery.

## Timing
- **Reset values:** `addr_q`=0, `addr_ok`=0, `addr_err`=0, all cnt=0, `soft_reset`=0. Consequently `write_enb`=0 and `fifo_full`=0 after reset.
- **Address to write_enb:** `detect_add` sampled at edge k; `write_enb`/`fifo_full` reflect the new address from edge k onward (same cycle as the first `write_enb_reg` of the header in the FSM's following state).
- **detect_add and write_enb_reg high together:** `write_enb` uses the previously latched address for that cycle.
- **full change:** `full` propagates to `fifo_full` in zero cycles (combinational).
- **soft_reset latency:** `soft_reset[i]` goes high after the TIMEOUT-th consecutive edge with `vld_out[i]`=1 and `read_enb[i]`=0.
- **Read strobe:** any `read_enb[i]` pulse, including one in the cycle cnt==TIMEOUT-1, suppresses the pulse and restarts the count.
- **Reset mid-count:** counters restart from 0. The first pulse comes TIMEOUT qualifying edges after `reset` deasserts.

## Structure
- **Shared `router_pkg`:** default `NUM_CH`, `ADDR_W`, `TIMEOUT`, and a `clog2` function, used by the FIFO and FSM blocks as well.
- **Sub-module `router_sync_timer`:** one per channel via generate. Ports: `clock`, `reset`, `vld`, `rd`, `soft_reset`; parameter `TIMEOUT`.
- **Top:** address register, write-enable decode, full mux, and `vld_out` assignment.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles with `empty`=3'b101 → `write_enb`=0, `fifo_full`=0, `soft_reset`=0, `addr_err`=0, `vld_out`=3'b010.
- **Valid address:** `detect_add`=1, `data_in`=2 for one edge, then `write_enb_reg`=1 with `full`=3'b100 → `write_enb`=3'b100, `fifo_full`=1. Drop `full` → `fifo_full`=0 in the same cycle.
- **Invalid address:** `data_in`=3 latched with `write_enb_reg`=1 → `addr_err`=1, `write_enb`=0, `fifo_full`=0. Latch `data_in`=0 → `addr_err`=0, `write_enb`=3'b001.
- **Timeout:** `empty[1]`=0, `read_enb[1]`=0 held → `soft_reset[1]`=1 for one cycle after the 30th edge, again after the 60th. `soft_reset[0]` and `soft_reset[2]` stay 0.
- **Read rescue:** as above, but `read_enb[1]`=1 for one cycle at count 29 → no pulse; the next pulse comes 30 edges later.
- **Reset mid-count:** `reset` pulse at count 20 → no pulse at edge 30; first pulse 30 edges after release. Simultaneous stall on channels 0 and 2 → both pulse in the same cycle.
